// File: rtl/xff_rr_sched_if.sv
// Handshake bundle between the source FIFOs, the round-robin scheduler and the downstream sink.
// src_en exists only when XFF_SCHED_MASK_EN is defined.
interface xff_rr_sched_if #(
    parameter int NUM_SRC = 4,
    parameter int DW      = 8
);
    localparam int SW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]    src_empty_n;
    logic [NUM_SRC*DW-1:0] src_q;
    logic [NUM_SRC-1:0]    src_re;
`ifdef XFF_SCHED_MASK_EN
    logic [NUM_SRC-1:0]    src_en;
`endif
    logic                  o_vld;
    logic [DW-1:0]         o_data;
    logic [SW-1:0]         o_src;
    logic                  o_rdy;
    logic                  busy;

    modport master (
        input  src_empty_n, src_q, o_rdy,
`ifdef XFF_SCHED_MASK_EN
        input  src_en,
`endif
        output src_re, o_vld, o_data, o_src, busy
    );

    modport slave (
        output src_empty_n, src_q, o_rdy,
`ifdef XFF_SCHED_MASK_EN
        output src_en,
`endif
        input  src_re, o_vld, o_data, o_src, busy
    );
endinterface

// File: rtl/xff_rr_sched.sv
// Round-robin burst drain scheduler: pops NUM_SRC show-ahead FIFOs onto one registered valid/ready stream.
// Optional per-source enable mask is compiled in with XFF_SCHED_MASK_EN.
module xff_rr_sched #(
    parameter int NUM_SRC   = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    xff_rr_sched_if.master    bus
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_reg, state_next;
    logic [SW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [SW-1:0]    grant_reg, grant_next;
    logic [CW-1:0]    burst_cnt_reg, burst_cnt_next;
    logic             o_vld_reg;
    logic [DW-1:0]    o_data_reg;
    logic [SW-1:0]    o_src_reg;

    logic [NUM_SRC-1:0] eligible;
    logic               can_load;
    logic               pop;
    logic [SW-1:0]      sel;
    logic               rr_found;
    logic [SW-1:0]      rr_pick;

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
        if (int'(v) == NUM_SRC - 1)
            return '0;
        else
            return v + 1'b1;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_elig
`ifdef XFF_SCHED_MASK_EN
            assign eligible[gi] = bus.src_en[gi] & bus.src_empty_n[gi];
`else
            assign eligible[gi] = bus.src_empty_n[gi];
`endif
            assign bus.src_re[gi] = pop && (sel == SW'(gi));
        end
    endgenerate

    assign can_load = !o_vld_reg || bus.o_rdy;

    // Scan downward so the last hit, i.e. the nearest one at or above rr_ptr, wins.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = rr_ptr_reg;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_SRC)
                idx = idx - NUM_SRC;
            if (eligible[idx]) begin
                rr_found = 1'b1;
                rr_pick  = SW'(idx);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = grant_reg;
        burst_cnt_next = burst_cnt_reg;
        pop            = 1'b0;
        sel            = grant_reg;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (rr_found && can_load) begin
                        pop            = 1'b1;
                        sel            = rr_pick;
                        burst_cnt_next = CW'(1);
                        if (MAX_BURST == 1) begin
                            rr_ptr_next = wrap_inc(rr_pick);
                        end else begin
                            state_next = BURST;
                            grant_next = rr_pick;
                        end
                    end
                end
                BURST: begin
                    // A drained or masked-off source releases the grant without popping anyone.
                    if (!eligible[grant_reg]) begin
                        state_next  = IDLE;
                        rr_ptr_next = wrap_inc(grant_reg);
                    end else if (can_load) begin
                        pop            = 1'b1;
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                        if (int'(burst_cnt_reg) + 1 >= MAX_BURST) begin
                            state_next  = IDLE;
                            rr_ptr_next = wrap_inc(grant_reg);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            burst_cnt_reg <= '0;
            o_vld_reg     <= 1'b0;
            o_data_reg    <= '0;
            o_src_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            burst_cnt_reg <= burst_cnt_next;
            if (pop) begin
                o_vld_reg  <= 1'b1;
                o_data_reg <= bus.src_q[sel*DW +: DW];
                o_src_reg  <= sel;
            end else if (o_vld_reg && bus.o_rdy) begin
                o_vld_reg <= 1'b0;
            end
        end
    end

    assign bus.o_vld  = o_vld_reg;
    assign bus.o_data = o_data_reg;
    assign bus.o_src  = o_src_reg;
    assign bus.busy   = (state_reg == BURST);
endmodule

// File: tb/tb_xff_rr_sched.sv
// Directed bench: two schedulers (MAX_BURST=4 and MAX_BURST=1) each draining a small FIFO model.
// Expected grant sequences, data words and busy flags are hand-derived per cycle.
module tb_xff_rr_sched;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    xff_rr_sched_if #(.NUM_SRC(4), .DW(8)) ifa ();
    xff_rr_sched_if #(.NUM_SRC(4), .DW(8)) ifb ();

    xff_rr_sched #(.NUM_SRC(4), .DW(8), .MAX_BURST(4)) u_b4 (.clk(clk), .rst(rst), .bus(ifa));
    xff_rr_sched #(.NUM_SRC(4), .DW(8), .MAX_BURST(1)) u_b1 (.clk(clk), .rst(rst), .bus(ifb));

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;
    int cnt_a[4];
    int head_a[4];
    int cnt_b[4];
    int head_b[4];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int s = 0; s < 4; s++) begin
            ifa.src_empty_n[s]    = (cnt_a[s] != 0);
            ifa.src_q[s*8 +: 8]   = 8'(s*64 + head_a[s]);
            ifb.src_empty_n[s]    = (cnt_b[s] != 0);
            ifb.src_q[s*8 +: 8]   = 8'(s*64 + head_b[s]);
        end
    endtask

    // Pops follow the read enables seen just before the edge, exactly as a real FIFO would.
    task automatic tick();
        logic [3:0] re_a;
        logic [3:0] re_b;
        @(negedge clk);
        re_a = ifa.src_re;
        re_b = ifb.src_re;
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            if (re_a[s]) begin
                check_eq($sformatf("pop_nonempty_a%0d", s), int'(cnt_a[s] != 0), 1);
                cnt_a[s]--;
                head_a[s]++;
            end
            if (re_b[s]) begin
                check_eq($sformatf("pop_nonempty_b%0d", s), int'(cnt_b[s] != 0), 1);
                cnt_b[s]--;
                head_b[s]++;
            end
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // ea/eb: expected o_src, -1 = o_vld low, -2 = unchecked; da/ba: data/busy, -1 = unchecked.
    task automatic step(input string tag, input logic rdy, input int ea, input int da,
                        input int ba, input int eb);
        ifa.o_rdy = rdy;
        ifb.o_rdy = rdy;
        #1;
        if (!rdy && ifa.o_vld)
            check_eq($sformatf("%s[%0d].stall_re", tag, step_no), int'(ifa.src_re), 0);
        tick();
        step_no++;
        if (ea != -2) begin
            check_eq($sformatf("%s[%0d].a_vld", tag, step_no), int'(ifa.o_vld), int'(ea >= 0));
            if (ea >= 0) begin
                check_eq($sformatf("%s[%0d].a_src", tag, step_no), int'(ifa.o_src), ea);
                if (da >= 0)
                    check_eq($sformatf("%s[%0d].a_data", tag, step_no), int'(ifa.o_data), da);
            end
            if (ba >= 0)
                check_eq($sformatf("%s[%0d].a_busy", tag, step_no), int'(ifa.busy), ba);
        end
        if (eb != -2) begin
            check_eq($sformatf("%s[%0d].b_vld", tag, step_no), int'(ifb.o_vld), int'(eb >= 0));
            if (eb >= 0)
                check_eq($sformatf("%s[%0d].b_src", tag, step_no), int'(ifb.o_src), eb);
            check_eq($sformatf("%s[%0d].b_busy", tag, step_no), int'(ifb.busy), 0);
        end
        $display("%s[%0d] a: vld=%0d src=%0d data=%0d busy=%0d | b: vld=%0d src=%0d",
                 tag, step_no, ifa.o_vld, ifa.o_src, ifa.o_data, ifa.busy, ifb.o_vld, ifb.o_src);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ifa.o_rdy = 1'b1;
        ifb.o_rdy = 1'b1;
`ifdef XFF_SCHED_MASK_EN
        ifa.src_en = 4'b1111;
        ifb.src_en = 4'b1111;
`endif
        for (int s = 0; s < 4; s++) begin
            cnt_a[s] = 3; head_a[s] = 0;
            cnt_b[s] = 3; head_b[s] = 0;
        end
        drive();

        // Reset held with every FIFO non-empty: nothing pops, outputs idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("rst%0d.a_re", i), int'(ifa.src_re), 0);
            check_eq($sformatf("rst%0d.b_re", i), int'(ifb.src_re), 0);
            check_eq($sformatf("rst%0d.a_vld", i), int'(ifa.o_vld), 0);
            check_eq($sformatf("rst%0d.a_busy", i), int'(ifa.busy), 0);
            check_eq($sformatf("rst%0d.a_data", i), int'(ifa.o_data), 0);
            check_eq($sformatf("rst%0d.a_src", i), int'(ifa.o_src), 0);
            check_eq($sformatf("rst%0d.b_vld", i), int'(ifb.o_vld), 0);
        end
        rst = 1'b0;
        #1;
        check_eq("first_pop.a_re", int'(ifa.src_re), 1);
        check_eq("first_pop.b_re", int'(ifb.src_re), 1);

        // Rotation (MAX_BURST=1) alongside early-release bursts (MAX_BURST=4), 3 words per source.
        step("rr", 1'b1,  0,   0, 1,  0);
        step("rr", 1'b1,  0,   1, 1,  1);
        step("rr", 1'b1,  0,   2, 1,  2);
        step("rr", 1'b1, -1,  -1, 0,  3);
        step("rr", 1'b1,  1,  64, 1,  0);
        step("rr", 1'b1,  1,  65, 1,  1);
        step("rr", 1'b1,  1,  66, 1,  2);
        step("rr", 1'b1, -1,  -1, 0,  3);
        step("rr", 1'b1,  2, 128, 1,  0);
        step("rr", 1'b1,  2, 129, 1,  1);
        step("rr", 1'b1,  2, 130, 1,  2);
        step("rr", 1'b1, -1,  -1, 0,  3);
        step("rr", 1'b1,  3, 192, 1, -1);
        step("rr", 1'b1,  3, 193, 1, -1);
        step("rr", 1'b1,  3, 194, 1, -1);
        step("rr", 1'b1, -1,  -1, 0, -1);

        // Burst cap: src1 has 6 words, src2 has 2, pointer at 0.
        cnt_a[1] = 6; head_a[1] = 0;
        cnt_a[2] = 2; head_a[2] = 0;
        drive();
        step("burst", 1'b1,  1,  64, 1, -2);
        step("burst", 1'b1,  1,  65, 1, -2);
        step("burst", 1'b1,  1,  66, 1, -2);
        step("burst", 1'b1,  1,  67, 0, -2);
        step("burst", 1'b1,  2, 128, 1, -2);
        step("burst", 1'b1,  2, 129, 1, -2);
        step("burst", 1'b1, -1,  -1, 0, -2);
        step("burst", 1'b1,  1,  68, 1, -2);
        step("burst", 1'b1,  1,  69, 1, -2);
        step("burst", 1'b1, -1,  -1, 0, -2);

        // Early release and pointer wrap from src3 back to src0.
        do_reset(1);
        cnt_a[0] = 2; head_a[0] = 0;
        cnt_a[3] = 1; head_a[3] = 0;
        drive();
        step("early", 1'b1,  0,   0, 1, -2);
        step("early", 1'b1,  0,   1, 1, -2);
        step("early", 1'b1, -1,  -1, 0, -2);
        step("early", 1'b1,  3, 192, 1, -2);
        step("early", 1'b1, -1,  -1, 0, -2);
        cnt_a[0] = 1; head_a[0] = 0;
        cnt_a[2] = 1; head_a[2] = 0;
        drive();
        step("wrap", 1'b1,  0,   0, 1, -2);
        step("wrap", 1'b1, -1,  -1, 0, -2);
        step("wrap", 1'b1,  2, 128, 1, -2);
        step("wrap", 1'b1, -1,  -1, 0, -2);

        // Backpressure mid-burst: 5 stalled cycles, burst count must not advance.
        cnt_a[2] = 6; head_a[2] = 0;
        drive();
        step("bp", 1'b1, 2, 128, 1, -2);
        step("bp", 1'b1, 2, 129, 1, -2);
        for (int i = 0; i < 5; i++)
            step("bp", 1'b0, 2, 129, 1, -2);
        step("bp", 1'b1,  2, 130, 1, -2);
        step("bp", 1'b1,  2, 131, 0, -2);
        step("bp", 1'b1,  2, 132, 1, -2);
        step("bp", 1'b1,  2, 133, 1, -2);
        step("bp", 1'b1, -1,  -1, 0, -2);
        check_eq("bp.drained", cnt_a[2], 0);

`ifdef XFF_SCHED_MASK_EN
        // Masked source 2 is never granted even though it holds data.
        do_reset(1);
        ifb.src_en = 4'b1011;
        for (int s = 0; s < 4; s++) begin
            cnt_b[s] = 2; head_b[s] = 0;
        end
        drive();
        step("mask", 1'b1, -2, -1, -1,  0);
        step("mask", 1'b1, -2, -1, -1,  1);
        step("mask", 1'b1, -2, -1, -1,  3);
        step("mask", 1'b1, -2, -1, -1,  0);
        step("mask", 1'b1, -2, -1, -1,  1);
        step("mask", 1'b1, -2, -1, -1,  3);
        step("mask", 1'b1, -2, -1, -1, -1);
        check_eq("mask.src2_untouched", cnt_b[2], 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
